// File: rtl/inst_issue_queue_pkg.sv
// Shared definitions for the instruction issue queue: payload layout, fault bit indices, defaults.
package inst_issue_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 32;

  // Payload field offsets/widths, LSB first
  localparam int IQ_PC_LSB      = 0;
  localparam int IQ_PC_W        = 32;
  localparam int IQ_INST_LSB    = 32;
  localparam int IQ_INST_W      = 32;
  localparam int IQ_BPADDR_LSB  = 64;
  localparam int IQ_BPADDR_W    = 32;
  localparam int IQ_BP_BIT      = 96;
  localparam int IQ_KERNEL_BIT  = 97;
  localparam int IQ_PAGING_BIT  = 98;
  localparam int IQ_FAULT_LSB   = 99;
  localparam int IQ_FAULT_W     = 3;

  localparam int IQ_FAULT_PAGE  = 0;
  localparam int IQ_FAULT_PRIV  = 1;
  localparam int IQ_FAULT_INV   = 2;

  typedef struct packed {
    logic [IQ_FAULT_W-1:0]  fault;
    logic                   paging;
    logic                   kernel;
    logic                   bp;
    logic [IQ_BPADDR_W-1:0] bp_addr;
    logic [IQ_INST_W-1:0]   inst;
    logic [IQ_PC_W-1:0]     pc;
  } iq_entry_t;

  localparam int IQ_PAYLOAD_W = $bits(iq_entry_t);

  // Write valids are contiguous from slot0; a lone slot1 valid is ignored.
  function automatic logic [1:0] wr_slots(input logic [1:0] vld);
    case (vld)
      2'b01:   wr_slots = 2'd1;
      2'b11:   wr_slots = 2'd2;
      default: wr_slots = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_issue_queue_ptr.sv
// Pointer/occupancy tracking for the issue queue, plus the lock and fetch-stop compares.
module inst_queue_ptr #(
  parameter int DEPTH   = 32,
  parameter int STOP_TH = DEPTH - 5,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [1:0]       wr_num_i,
  input  logic [1:0]       rd_num_i,
  output logic [PTR_W-1:0] wp_o,
  output logic [PTR_W-1:0] rp_o,
  output logic [CNT_W-1:0] count_o,
  output logic             lock_o,
  output logic             fetch_stop_o
);

  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wp_d    = wp_q + PTR_W'(wr_num_i);
    rp_d    = rp_q + PTR_W'(rd_num_i);
    count_d = count_q + CNT_W'(wr_num_i) - CNT_W'(rd_num_i);
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Lock leaves room for a full two-slot write; it is never relieved by a same-cycle pop.
  assign lock_o       = (DEPTH - int'(count_q)) < 2;
  assign fetch_stop_o = int'(count_q) > STOP_TH;
  assign wp_o         = wp_q;
  assign rp_o         = rp_q;
  assign count_o      = count_q;

endmodule

// File: rtl/inst_issue_queue.sv
// Two-wide in / two-wide out instruction issue queue (circular buffer, opaque payload).
// Optional same-cycle bypass on an empty queue: define MIST1032ISA_IBUF_BYPASS_EN.
module inst_issue_queue
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W,
  parameter int STOP_TH   = DEPTH - 5
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iFREE_REFRESH,
  input  logic [1:0]             iPREVIOUS_INST_VALID,
  input  logic [2*PAYLOAD_W-1:0] iPREVIOUS_DATA,
  output logic                   oPREVIOUS_LOCK,
  output logic                   oPREVIOUS_FETCH_STOP,
  output logic [1:0]             oNEXT_INST_VALID,
  output logic [2*PAYLOAD_W-1:0] oNEXT_DATA,
  input  logic                   iNEXT_LOCK,
  output logic [$clog2(DEPTH):0] oCOUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]            wp, rp, wp1, rp1;
  logic [CNT_W-1:0]            count;
  logic                        lock, fetch_stop;
  logic [1:0]                  wr_acc, wr_store, rd_num, rd_vld;
  logic [1:0][PAYLOAD_W-1:0]   wdata;
  logic [PAYLOAD_W-1:0]        mem [DEPTH];

  assign wdata  = iPREVIOUS_DATA;
  assign wp1    = wp + PTR_W'(1);
  assign rp1    = rp + PTR_W'(1);
  assign wr_acc = (lock || iFREE_REFRESH) ? 2'd0 : wr_slots(iPREVIOUS_INST_VALID);

  assign rd_vld[0] = (count != '0)        && !iNEXT_LOCK && !iFREE_REFRESH;
  assign rd_vld[1] = (count > CNT_W'(1))  && !iNEXT_LOCK && !iFREE_REFRESH;
  assign rd_num    = {1'b0, rd_vld[0]} + {1'b0, rd_vld[1]};

`ifdef MIST1032ISA_IBUF_BYPASS_EN
  logic byp;
  // Empty queue with a ready consumer: incoming slots go straight out and are not stored.
  assign byp              = (count == '0) && !iNEXT_LOCK && !iFREE_REFRESH && inRESET;
  assign wr_store         = byp ? 2'd0 : wr_acc;
  assign oNEXT_INST_VALID = byp ? {wr_acc == 2'd2, wr_acc != 2'd0} : rd_vld;
  assign oNEXT_DATA       = byp ? iPREVIOUS_DATA : {mem[rp1], mem[rp]};
`else
  assign wr_store         = wr_acc;
  assign oNEXT_INST_VALID = rd_vld;
  assign oNEXT_DATA       = {mem[rp1], mem[rp]};
`endif

  always_ff @(posedge iCLOCK) begin
    if (wr_store != 2'd0) mem[wp]  <= wdata[0];
    if (wr_store == 2'd2) mem[wp1] <= wdata[1];
  end

  inst_queue_ptr #(
    .DEPTH   (DEPTH),
    .STOP_TH (STOP_TH)
  ) u_ptr (
    .clk_i        (iCLOCK),
    .rst_ni       (inRESET),
    .flush_i      (iFREE_REFRESH),
    .wr_num_i     (wr_store),
    .rd_num_i     (rd_num),
    .wp_o         (wp),
    .rp_o         (rp),
    .count_o      (count),
    .lock_o       (lock),
    .fetch_stop_o (fetch_stop)
  );

  assign oPREVIOUS_LOCK       = lock;
  assign oPREVIOUS_FETCH_STOP = fetch_stop;
  assign oCOUNT               = count;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed + randomised bench for inst_issue_queue with a payload scoreboard.
module tb_inst_issue_queue;
  import inst_issue_queue_pkg::*;

  localparam int DEPTH = 32;
  localparam int PW    = IQ_PAYLOAD_W;
  localparam int CW    = $clog2(DEPTH) + 1;
  typedef logic [PW-1:0] pl_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            nlock = 1'b0;
  logic [1:0]      wv = 2'b00;
  logic [2*PW-1:0] wdata = '0;
  logic            lock, stop;
  logic [1:0]      rv;
  logic [2*PW-1:0] rdata;
  logic [CW-1:0]   cnt;

  int   checks = 0;
  int   failures = 0;
  int   seq = 0;
  pl_t  sb[$];

  always #5 clk = ~clk;

  inst_issue_queue #(.DEPTH(DEPTH)) dut (
    .iCLOCK               (clk),
    .inRESET              (rst_n),
    .iFREE_REFRESH        (flush),
    .iPREVIOUS_INST_VALID (wv),
    .iPREVIOUS_DATA       (wdata),
    .oPREVIOUS_LOCK       (lock),
    .oPREVIOUS_FETCH_STOP (stop),
    .oNEXT_INST_VALID     (rv),
    .oNEXT_DATA           (rdata),
    .iNEXT_LOCK           (nlock),
    .oCOUNT               (cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t mk(input int n);
    iq_entry_t e;
    e.pc      = 32'(n) * 32'd4;
    e.inst    = 32'hE000_0000 ^ 32'(n);
    e.bp_addr = ~32'(n);
    e.bp      = n[0];
    e.kernel  = n[1];
    e.paging  = n[2];
    e.fault   = n[5:3];
    return e;
  endfunction

  // Called just after a falling edge; checks outputs, then advances the model at the rising edge.
  task automatic cyc(input logic [1:0] v, input logic nl, input logic fl, input string tag);
    pl_t        d0, d1;
    int         n;
    logic       lk, byp;
    logic [1:0] acc, exp_rv;
    d0 = mk(seq);
    d1 = mk(seq + 1);
    wv = v; nlock = nl; flush = fl; wdata = {d1, d0};
    #1;
    n   = sb.size();
    lk  = (DEPTH - n) < 2;
    acc = (!lk && !fl) ? ((v == 2'b01) ? 2'b01 : (v == 2'b11) ? 2'b11 : 2'b00) : 2'b00;
    byp = 1'b0;
`ifdef MIST1032ISA_IBUF_BYPASS_EN
    byp = (n == 0) && !nl && !fl;
`endif
    if (byp)           exp_rv = acc;
    else if (nl || fl) exp_rv = 2'b00;
    else               exp_rv = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    chk({tag, ".count"}, 128'(cnt),  128'(n));
    chk({tag, ".lock"},  128'(lock), 128'(lk));
    chk({tag, ".stop"},  128'(stop), 128'(n > DEPTH - 5));
    chk({tag, ".valid"}, 128'(rv),   128'(exp_rv));
    if (byp) begin
      if (exp_rv[0]) chk({tag, ".byp0"}, 128'(rdata[PW-1:0]),    128'(d0));
      if (exp_rv[1]) chk({tag, ".byp1"}, 128'(rdata[2*PW-1:PW]), 128'(d1));
    end else begin
      if (exp_rv[0]) chk({tag, ".data0"}, 128'(rdata[PW-1:0]),    128'(sb[0]));
      if (exp_rv[1]) chk({tag, ".data1"}, 128'(rdata[2*PW-1:PW]), 128'(sb[1]));
    end
    @(posedge clk);
    if (fl) sb.delete();
    else if (!byp) begin
      if (exp_rv[0]) void'(sb.pop_front());
      if (exp_rv[1]) void'(sb.pop_front());
      if (acc[0]) sb.push_back(d0);
      if (acc[1]) sb.push_back(d1);
    end
    if (!fl) seq += int'(acc[0]) + int'(acc[1]);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with writes being driven: everything must stay quiet
    wv = 2'b11; wdata = {mk(900), mk(901)};
    repeat (3) @(negedge clk);
    chk("rst.count", 128'(cnt),  128'(0));
    chk("rst.valid", 128'(rv),   128'(0));
    chk("rst.lock",  128'(lock), 128'(0));
    chk("rst.stop",  128'(stop), 128'(0));
    rst_n = 1'b1;

    // Fill with two-wide writes while the consumer is stalled
    for (int i = 0; i < 16; i++) cyc(2'b11, 1'b1, 1'b0, "fill");
    cyc(2'b11, 1'b1, 1'b0, "sat");
    chk("sat.final", 128'(cnt), 128'(DEPTH));

    // Asynchronous reset in the middle of a cycle with a full queue
    rst_n = 1'b0;
    #1;
    chk("mid_rst.count", 128'(cnt),  128'(0));
    chk("mid_rst.valid", 128'(rv),   128'(0));
    chk("mid_rst.lock",  128'(lock), 128'(0));
    chk("mid_rst.stop",  128'(stop), 128'(0));
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;

    // A, B, C single writes then release the consumer
    cyc(2'b01, 1'b1, 1'b0, "wrA");
    cyc(2'b01, 1'b1, 1'b0, "wrB");
    cyc(2'b01, 1'b1, 1'b0, "wrC");
    cyc(2'b00, 1'b0, 1'b0, "rel1");
    cyc(2'b00, 1'b0, 1'b0, "rel2");
    chk("rel.final", 128'(cnt), 128'(0));

    // Flush with a concurrent write at count 10
    for (int i = 0; i < 5; i++) cyc(2'b11, 1'b1, 1'b0, "pre_flush");
    cyc(2'b11, 1'b0, 1'b1, "flush");
    cyc(2'b00, 1'b0, 1'b0, "post_flush");

    // Lone slot1 valid writes nothing
    cyc(2'b01, 1'b1, 1'b0, "w01");
    cyc(2'b10, 1'b1, 1'b0, "w10");
    cyc(2'b00, 1'b1, 1'b0, "w10_after");
    cyc(2'b00, 1'b0, 1'b0, "drain1");

    // Steady 2-in/2-out streaming across several pointer wraps
    cyc(2'b11, 1'b1, 1'b0, "prime");
    cyc(2'b11, 1'b1, 1'b0, "prime");
    for (int i = 0; i < 3 * DEPTH; i++) cyc(2'b11, 1'b0, 1'b0, "stream");
    chk("stream.final", 128'(cnt), 128'(4));
    cyc(2'b00, 1'b0, 1'b0, "drain2");
    cyc(2'b00, 1'b0, 1'b0, "drain3");

    // Empty-queue write with a ready consumer (bypass or one-cycle latency)
    cyc(2'b11, 1'b0, 1'b0, "byp");
    cyc(2'b00, 1'b0, 1'b0, "byp_next");
    cyc(2'b00, 1'b0, 1'b0, "byp_idle");

    // Random traffic biased towards filling, with occasional flushes
    for (int i = 0; i < 400; i++) begin
      logic [1:0] rv_w;
      logic       rnl, rfl;
      rv_w = 2'($urandom_range(0, 3));
      rnl  = ($urandom_range(0, 3) != 0);
      rfl  = ($urandom_range(0, 63) == 0);
      cyc(rv_w, rnl, rfl, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_issue_queue.md
INST_ISSUE_QUEUE -- requirements
Module: inst_issue_queue

Interface
REQ-001 Parameter DEPTH, default 32, is the entry count; it SHALL be a power of two and at least 4.
REQ-002 Parameter PAYLOAD_W, default 102, is the width of one entry: {fault[2:0], paging, kernel, bp, bp_addr[31:0], inst[31:0], pc[31:0]}.
REQ-003 Parameter STOP_TH, default DEPTH-5, is the fetch-stop threshold.
REQ-004 Ports SHALL be, clock and reset first:
- iCLOCK  in  1  -- sole clock; all state changes on the rising edge.
- inRESET  in  1  -- asynchronous, active-low reset.
- iFREE_REFRESH  in  1  -- flush.
- iPREVIOUS_INST_VALID  in  2  -- per-slot write valid; slot0 is older.
- iPREVIOUS_DATA  in  2*PAYLOAD_W  -- slot0 occupies the LSBs.
- oPREVIOUS_LOCK  out  1  -- writer must hold.
- oPREVIOUS_FETCH_STOP  out  1  -- early throttle.
- oNEXT_INST_VALID  out  2  -- per-slot read valid.
- oNEXT_DATA  out  2*PAYLOAD_W  -- slot0 is the queue head.
- iNEXT_LOCK  in  1  -- consumer stall.
- oCOUNT  out  $clog2(DEPTH)+1  -- occupancy.

Function
REQ-005 Storage SHALL be a circular buffer with write pointer wp, read pointer rp and count, all modulo DEPTH with natural wrap.
REQ-006 The queue SHALL assert oPREVIOUS_LOCK when DEPTH-count < 2.
REQ-007 A write SHALL be accepted only when oPREVIOUS_LOCK=0 and iFREE_REFRESH=0.
REQ-008 Write valid SHALL be treated as contiguous: 2'b01 writes one entry, 2'b11 writes two (slot0 then slot1), and 2'b10 and 2'b00 write nothing.
REQ-009 Read valids SHALL be oNEXT_INST_VALID[0] = count>=1 & !iNEXT_LOCK & !iFREE_REFRESH, and oNEXT_INST_VALID[1] = count>=2 & !iNEXT_LOCK & !iFREE_REFRESH.
REQ-010 oNEXT_DATA SHALL present entries rp and rp+1 combinationally; a slot whose valid is low carries don't-care data.
REQ-011 Every asserted read valid SHALL pop one entry in that cycle; the consumer has no per-slot refusal.
REQ-012 Same-cycle write and pop SHALL update count by +writes-pops.
REQ-013 A full queue SHALL accept a write in the same cycle a pop frees space only if DEPTH-count >= 2 before the pop; lock is not relieved combinationally.
REQ-014 iFREE_REFRESH SHALL set wp=rp=count=0 at the next edge and discard any same-cycle write and pop.
REQ-015 Write-to-read latency SHALL be 1 cycle: an entry written at edge N is visible after edge N.
REQ-016 oPREVIOUS_FETCH_STOP SHALL be count > STOP_TH, combinational from the registered count.
REQ-017 oCOUNT SHALL equal the registered count.
REQ-018 Entry ordering SHALL be strict FIFO; no entry is lost or duplicated across pointer wrap.

Reset
REQ-019 While inRESET=0, wp, rp and count SHALL be 0, both valids SHALL be 0, lock SHALL be 0 and fetch-stop SHALL be 0, independent of clock.
REQ-020 Assertion of reset mid-operation SHALL discard all contents, and the first write after release SHALL be accepted.
REQ-021 Storage array contents SHALL NOT be reset.

Configuration
REQ-022 Macro MIST1032ISA_IBUF_BYPASS_EN, when defined, SHALL enable bypass: with count=0, !iNEXT_LOCK and !iFREE_REFRESH, the accepted write slots SHALL appear on oNEXT_* in the same cycle with matching valids, and SHALL NOT be stored.
REQ-023 Without MIST1032ISA_IBUF_BYPASS_EN, there SHALL be no combinational path from iPREVIOUS_* to oNEXT_*, and latency SHALL be exactly per REQ-015.

Structure
REQ-024 Shared package/header (core.h) SHALL hold the payload field offsets and widths, the fault bit indices (0 pagefault, 1 privilege, 2 invalid-inst) and the default DEPTH.
REQ-025 The design SHALL have one sub-module, inst_queue_ptr, covering wp/rp/count update and the lock/threshold compare; storage and muxing stay in the top.
REQ-026 The payload SHALL be opaque; fault generation remains upstream.

Verification
REQ-027 Reset, then write 2'b11 for 16 cycles with iNEXT_LOCK=1 -> lock asserts when count=31, fetch-stop asserts when count=28, and count saturates at 31 or 32 without overflow.
REQ-028 Write single entries A,B,C, then release the lock -> cycle 1 valid=2'b11 with A,B; cycle 2 valid=2'b01 with C; count ends at 0.
REQ-029 With count=10, assert iFREE_REFRESH together with a 2'b11 write -> next cycle count=0, valid=2'b00, and no stale data appears.
REQ-030 Continuous 2-in/2-out for 3*DEPTH cycles with incrementing pc -> the output pc sequence is contiguous across wrap and count stays constant.
REQ-031 Apply write 2'b10 -> no entry written and count unchanged.
REQ-032 With MIST1032ISA_IBUF_BYPASS_EN and count=0, write 2'b11 with payloads X,Y -> same-cycle valid=2'b11 with X,Y and count stays 0; without the macro, X,Y appear one cycle later.
